layer_compositor: RTL and testbench

- Parametrised successor to the single-layer text paint stage.
- Merges LAYERS independent paint sources (text, bitmap, sprites, ...) by fixed priority, with layer 0 highest.
- Drives an external CLUT read port and aligns display timing signals to the CLUT read latency.
- Produces registered RGB display outputs.
- Sits between the layer generators, CLUT and display controller, all in the pixel clock domain.

---
 rtl/layer_compositor_pkg.sv | 28 ++
 rtl/layer_compositor_sig_delay.sv | 25 ++
 rtl/layer_compositor.sv | 147 ++++++++++++++
 tb/tb_layer_compositor.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/layer_compositor_pkg.sv
// Shared constants and payload types for the layer compositor and its consumers.
// The optional COMPOSITOR_TRANSP_EN build makes colour index 0 transparent.
package layer_compositor_pkg;

  localparam int unsigned BPC_DEF    = 5;
  localparam int unsigned CORDW_DEF  = 16;
  localparam int unsigned LAYERS_DEF = 2;
  localparam int unsigned CIDXW_DEF  = 8;
  localparam int unsigned CLUT_LAT   = 2;
  localparam int unsigned COLRW      = 3 * BPC_DEF;

  // Input-to-output latency: select stage + CLUT read + output register.
  localparam int unsigned LAT = CLUT_LAT + 2;

  // Per-pixel flags carried down the delay line next to the position.
  typedef struct packed {
    logic hit;
    logic frame;
    logic hsync;
    logic vsync;
    logic de;
  } tim_t;

  function automatic int unsigned comp_lat(input int unsigned clut_lat);
    return clut_lat + 2;
  endfunction

endpackage

// File: rtl/layer_compositor_sig_delay.sv
// WIDTH x DEPTH shift register with synchronous active-low reset.
module layer_compositor_sig_delay #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/layer_compositor.sv
// Priority merge of LAYERS paint sources through an external CLUT into registered RGB.
// Build option: COMPOSITOR_TRANSP_EN treats colour index 0 as transparent.
module layer_compositor
  import layer_compositor_pkg::*;
#(
  parameter int unsigned BPC      = BPC_DEF,
  parameter int unsigned CORDW    = CORDW_DEF,
  parameter int unsigned LAYERS   = LAYERS_DEF,
  parameter int unsigned CIDXW    = CIDXW_DEF,
  parameter int unsigned CLUT_LAT = layer_compositor_pkg::CLUT_LAT
) (
  input  logic                      clk_pix,
  input  logic                      rst_pix,
  input  logic                      frame_start,
  input  logic signed [CORDW-1:0]   dx,
  input  logic signed [CORDW-1:0]   dy,
  input  logic                      hsync,
  input  logic                      vsync,
  input  logic                      de,
  input  logic [LAYERS*CIDXW-1:0]   layer_cidx,
  input  logic [LAYERS-1:0]         layer_paint,
  input  logic [LAYERS-1:0]         layer_en,
  input  logic [3*BPC-1:0]          bg_colr,
  output logic [CIDXW-1:0]          clut_addr,
  input  logic [3*BPC-1:0]          clut_data,
  output logic signed [CORDW-1:0]   disp_x,
  output logic signed [CORDW-1:0]   disp_y,
  output logic                      disp_hsync,
  output logic                      disp_vsync,
  output logic                      disp_de,
  output logic                      disp_frame,
  output logic [BPC-1:0]            disp_r,
  output logic [BPC-1:0]            disp_g,
  output logic [BPC-1:0]            disp_b
);

  localparam int unsigned COLW = 3 * BPC;
  localparam int unsigned TIMW = $bits(tim_t);
  localparam int unsigned BUNW = 2 * CORDW + TIMW;

  logic [LAYERS-1:0] en_q;
  logic [COLW-1:0]   bg_q;

  logic [LAYERS-1:0] elig_c;
  logic              win_c;
  logic [CIDXW-1:0]  win_cidx_c;
  tim_t              tim_c;
  logic [BUNW-1:0]   bun_c;

  logic [BUNW-1:0]   bun_s1;
  logic [BUNW-1:0]   bun_d;
  logic [CORDW-1:0]  x_d;
  logic [CORDW-1:0]  y_d;
  tim_t              tim_d;
  logic [COLW-1:0]   colour_c;

  // Layer config is shadowed at frame start; the pixel of that cycle still sees the old set.
  always_ff @(posedge clk_pix) begin
    if (!rst_pix) begin
      en_q <= '1;
      bg_q <= '0;
    end else if (frame_start) begin
      en_q <= layer_en;
      bg_q <= bg_colr;
    end
  end

  // Eligible layers, then lowest index wins (scan from the top so the last match is kept).
  always_comb begin
    elig_c     = layer_paint & en_q;
`ifdef COMPOSITOR_TRANSP_EN
    for (int n = 0; n < int'(LAYERS); n++) begin
      if (layer_cidx[n*CIDXW +: CIDXW] == '0) elig_c[n] = 1'b0;
    end
`endif
    win_c      = 1'b0;
    win_cidx_c = '0;
    for (int n = int'(LAYERS) - 1; n >= 0; n--) begin
      if (elig_c[n]) begin
        win_c      = 1'b1;
        win_cidx_c = layer_cidx[n*CIDXW +: CIDXW];
      end
    end
  end

  always_comb begin
    tim_c       = '0;
    tim_c.hit   = win_c;
    tim_c.frame = frame_start;
    tim_c.hsync = hsync;
    tim_c.vsync = vsync;
    tim_c.de    = de;
    bun_c       = {dx, dy, tim_c};
  end

  // Select stage: CLUT address keeps its last value when nothing paints.
  always_ff @(posedge clk_pix) begin
    if (!rst_pix) begin
      clut_addr <= '0;
      bun_s1    <= '0;
    end else begin
      bun_s1 <= bun_c;
      if (win_c) clut_addr <= win_cidx_c;
    end
  end

  layer_compositor_sig_delay #(
    .WIDTH (BUNW),
    .DEPTH (CLUT_LAT)
  ) u_dly (
    .clk   (clk_pix),
    .rst_n (rst_pix),
    .d     (bun_s1),
    .q     (bun_d)
  );

  assign x_d      = bun_d[BUNW-1 -: CORDW];
  assign y_d      = bun_d[BUNW-CORDW-1 -: CORDW];
  assign tim_d    = tim_t'(bun_d[TIMW-1:0]);
  assign colour_c = tim_d.hit ? clut_data : bg_q;

  // Output stage: blanking forces black.
  always_ff @(posedge clk_pix) begin
    if (!rst_pix) begin
      disp_x     <= '0;
      disp_y     <= '0;
      disp_hsync <= 1'b0;
      disp_vsync <= 1'b0;
      disp_de    <= 1'b0;
      disp_frame <= 1'b0;
      disp_r     <= '0;
      disp_g     <= '0;
      disp_b     <= '0;
    end else begin
      disp_x     <= x_d;
      disp_y     <= y_d;
      disp_hsync <= tim_d.hsync;
      disp_vsync <= tim_d.vsync;
      disp_de    <= tim_d.de;
      disp_frame <= tim_d.frame;
      disp_r     <= tim_d.de ? colour_c[COLW-1 -: BPC]  : '0;
      disp_g     <= tim_d.de ? colour_c[2*BPC-1 -: BPC] : '0;
      disp_b     <= tim_d.de ? colour_c[BPC-1:0]        : '0;
    end
  end

endmodule

// File: tb/tb_layer_compositor.sv
// Directed bench for layer_compositor with LAYERS=3, CIDXW=8, BPC=5, CLUT_LAT=2.
module tb_layer_compositor;
  import layer_compositor_pkg::*;

  localparam int unsigned BPC    = 5;
  localparam int unsigned CORDW  = 16;
  localparam int unsigned LAYERS = 3;
  localparam int unsigned CIDXW  = 8;

  logic                    clk_pix;
  logic                    rst_pix;
  logic                    frame_start;
  logic signed [CORDW-1:0] dx, dy;
  logic                    hsync, vsync, de;
  logic [LAYERS*CIDXW-1:0] layer_cidx;
  logic [LAYERS-1:0]       layer_paint;
  logic [LAYERS-1:0]       layer_en;
  logic [3*BPC-1:0]        bg_colr;
  logic [CIDXW-1:0]        clut_addr;
  logic [3*BPC-1:0]        clut_data;
  logic signed [CORDW-1:0] disp_x, disp_y;
  logic                    disp_hsync, disp_vsync, disp_de, disp_frame;
  logic [BPC-1:0]          disp_r, disp_g, disp_b;

  logic [CIDXW-1:0] c0, c1, c2;
  logic [3*BPC-1:0] clut_p1;
  int n_checks;
  int n_errors;

  assign layer_cidx = {c2, c1, c0};

  layer_compositor #(
    .BPC(BPC), .CORDW(CORDW), .LAYERS(LAYERS), .CIDXW(CIDXW), .CLUT_LAT(2)
  ) dut (
    .clk_pix(clk_pix), .rst_pix(rst_pix), .frame_start(frame_start),
    .dx(dx), .dy(dy), .hsync(hsync), .vsync(vsync), .de(de),
    .layer_cidx(layer_cidx), .layer_paint(layer_paint), .layer_en(layer_en),
    .bg_colr(bg_colr), .clut_addr(clut_addr), .clut_data(clut_data),
    .disp_x(disp_x), .disp_y(disp_y), .disp_hsync(disp_hsync),
    .disp_vsync(disp_vsync), .disp_de(disp_de), .disp_frame(disp_frame),
    .disp_r(disp_r), .disp_g(disp_g), .disp_b(disp_b)
  );

  initial clk_pix = 1'b0;
  always #5 clk_pix = ~clk_pix;

  // Two-cycle CLUT: data = idx[4:0] replicated on every channel.
  always @(posedge clk_pix) begin
    clut_p1   <= {clut_addr[4:0], clut_addr[4:0], clut_addr[4:0]};
    clut_data <= clut_p1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_pix);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rgb(input string tag, input logic [4:0] r, input logic [4:0] g,
                         input logic [4:0] b);
    chk({tag, "_r"}, 32'(disp_r), 32'(r));
    chk({tag, "_g"}, 32'(disp_g), 32'(g));
    chk({tag, "_b"}, 32'(disp_b), 32'(b));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_pix = 1'b0; frame_start = 1'b0; dx = '0; dy = '0;
    hsync = 1'b0; vsync = 1'b0; de = 1'b0;
    c0 = 8'h05; c1 = 8'h0A; c2 = 8'h0C;
    layer_paint = '0; layer_en = 3'b111; bg_colr = 15'h7FFF;

    // Reset state
    tick(3);
    chk("rst_addr", 32'(clut_addr), 32'h0);
    chk("rst_de", 32'(disp_de), 32'h0);
    chk_rgb("rst", 5'h00, 5'h00, 5'h00);

    // Load config via frame_start with blanking
    rst_pix = 1'b1; frame_start = 1'b1;
    tick(1);

    // Latency: single pixel A
    frame_start = 1'b0; de = 1'b1; layer_paint = 3'b001; dx = 16'sd10; dy = 16'sd20; hsync = 1'b1;
    tick(1);
    chk("lat_addr", 32'(clut_addr), 32'h05);
    de = 1'b0; layer_paint = 3'b000; dx = 16'sd11; hsync = 1'b0;
    tick(2);
    chk("lat_pre_de", 32'(disp_de), 32'h0);
    tick(1);
    chk_rgb("lat", 5'h05, 5'h05, 5'h05);
    chk("lat_de", 32'(disp_de), 32'h1);
    chk("lat_x", 32'(disp_x), 32'd10);
    chk("lat_y", 32'(disp_y), 32'd20);
    chk("lat_hs", 32'(disp_hsync), 32'h1);
    tick(1);
    chk("lat_post_de", 32'(disp_de), 32'h0);
    chk("lat_post_x", 32'(disp_x), 32'd11);
    chk("lat_post_r", 32'(disp_r), 32'h0);

    // Priority
    de = 1'b1; layer_paint = 3'b110;
    tick(LAT);
    chk_rgb("pri_110", 5'h0A, 5'h0A, 5'h0A);
    layer_paint = 3'b100;
    tick(LAT);
    chk_rgb("pri_100", 5'h0C, 5'h0C, 5'h0C);
    layer_paint = 3'b000;
    tick(LAT);
    chk_rgb("pri_bg", 5'h1F, 5'h1F, 5'h1F);

    // Shadowing: mid-frame config change ignored until frame_start
    layer_paint = 3'b001; layer_en = 3'b110; bg_colr = 15'h001F;
    tick(LAT);
    chk_rgb("shd_mid", 5'h05, 5'h05, 5'h05);
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    tick(3);
    chk_rgb("shd_fs_pix", 5'h05, 5'h05, 5'h05);
    chk("shd_frame", 32'(disp_frame), 32'h1);
    tick(1);
    chk_rgb("shd_new", 5'h00, 5'h00, 5'h1F);
    chk("shd_frame_lo", 32'(disp_frame), 32'h0);

    // Restore config, then blanking
    layer_en = 3'b111; bg_colr = 15'h7FFF; frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    tick(LAT);
    de = 1'b0; hsync = 1'b1; vsync = 1'b1; c0 = 8'h1F;
    tick(1);
    de = 1'b1; hsync = 1'b0; vsync = 1'b0; c0 = 8'h05;
    tick(2);
    chk("blk_pre_hs", 32'(disp_hsync), 32'h0);
    chk("blk_pre_de", 32'(disp_de), 32'h1);
    tick(1);
    chk_rgb("blk", 5'h00, 5'h00, 5'h00);
    chk("blk_hs", 32'(disp_hsync), 32'h1);
    chk("blk_vs", 32'(disp_vsync), 32'h1);
    chk("blk_de", 32'(disp_de), 32'h0);
    tick(1);
    chk("blk_post_de", 32'(disp_de), 32'h1);
    chk("blk_post_r", 32'(disp_r), 32'h05);

    // All layers disabled: background only
    layer_en = 3'b000; frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    tick(LAT);
    chk_rgb("dis", 5'h1F, 5'h1F, 5'h1F);

    // Reset mid-line: en_q returns to all ones, bg_q to 0
    rst_pix = 1'b0;
    tick(1);
    chk_rgb("mrst", 5'h00, 5'h00, 5'h00);
    chk("mrst_addr", 32'(clut_addr), 32'h0);
    chk("mrst_de", 32'(disp_de), 32'h0);
    rst_pix = 1'b1;
    tick(3);
    chk("mrst_fill_de", 32'(disp_de), 32'h0);
    tick(1);
    chk("mrst_resume_de", 32'(disp_de), 32'h1);
    chk_rgb("mrst_resume", 5'h05, 5'h05, 5'h05);

    // Transparency of index 0
    layer_paint = 3'b011; c0 = 8'h00; c1 = 8'h07;
    tick(LAT);
`ifdef COMPOSITOR_TRANSP_EN
    chk_rgb("transp", 5'h07, 5'h07, 5'h07);
`else
    chk_rgb("transp", 5'h00, 5'h00, 5'h00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
